mandelbrot_frame_scheduler: RTL and testbench
=============================================

Name: mandelbrot_frame_scheduler

Overview:
- Sequences one Mandelbrot frame render into the frame buffer read by the VGA output path.
- Walks every pixel coordinate of the half-resolution frame (320x240), dispatches pixel jobs to NUM_CORES iteration cores over valid/ready, and collects their colour results.
- Round-robin arbitration of results onto the single frame-buffer write port (addr/data/we).
- Signals frame completion so the top level can start the next frame or a new zoom.

Parameters:
- NUM_CORES, 4, number of iteration cores served (1..8)
- H_RES, 320, pixels per frame line
- V_RES, 240, lines per frame
- ADDR_WIDTH, 17, frame-buffer address width (must hold H_RES*V_RES-1)
- DATA_WIDTH, 12, pixel colour width (4:4:4 RGB)

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  1-cycle pulse: begin rendering a frame
- o_busy  out  1  high from accepted start until done
- o_done  out  1  1-cycle pulse when last pixel written
- o_job_valid  out  NUM_CORES  one-hot job offer, bit k to core k
- i_job_ready  in  NUM_CORES  core k can accept a job
- o_job_x  out  10  pixel column of offered job (shared by all cores)
- o_job_y  out  9  pixel line of offered job (shared)
- o_job_addr  out  ADDR_WIDTH  frame-buffer address of offered job; core returns it with its result
- i_res_valid  in  NUM_CORES  core k has a result
- o_res_ready  out  NUM_CORES  one-hot result grant
- i_res_addr  in  NUM_CORES*ADDR_WIDTH  result addresses, core k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- i_res_data  in  NUM_CORES*DATA_WIDTH  result colours, same packing
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  ADDR_WIDTH  write address
- o_wr_data  out  DATA_WIDTH  write data

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; state IDLE.
  - x, y, outstanding count, RR pointer cleared (pointer=0).
  - Applies mid-frame too: in-flight jobs are abandoned; cores must also be reset.
- FSM states:
  - IDLE: o_busy=0. i_start=1 -> DISPATCH; next cycle x=y=0, o_busy=1.
  - DISPATCH: offer current (x,y) to the lowest-index core with i_job_ready=1; o_job_valid combinationally one-hot on that bit, 0 if none ready.
    - Handshake = valid & ready in the same cycle; on handshake advance x.
    - x==H_RES-1 wraps to 0 and increments y.
    - Handshake at (H_RES-1, V_RES-1) -> DRAIN.
  - DRAIN: no job offers; wait until outstanding==0 and write pipeline empty -> DONE.
  - DONE: o_done=1 for exactly one cycle, o_busy=0 -> IDLE.
- i_start while o_busy=1 is ignored.
- Job address:
  - o_job_addr = y*H_RES + x, held in a register updated with x/y. No multiplier: increment by 1 per job.
  - Address matches the x/y it accompanies in every cycle.
- Result arbiter:
  - Round-robin over i_res_valid, starting at the RR pointer; o_res_ready one-hot, combinational, asserted in any state except IDLE.
  - On grant to core k, the pointer moves to k+1 mod NUM_CORES.
  - Granted addr/data are registered; o_wr_en=1 the following cycle (1-cycle latency), at most one write per cycle.
- Outstanding counter (width clog2(H_RES*V_RES)+1):
  - +1 on job handshake, -1 on result grant; both in the same cycle -> unchanged.
  - Underflow (grant with count 0) must not occur; assertion in sim.
- DRAIN->DONE only after the final write cycle has been driven, so o_done follows the last o_wr_en by >=1 cycle.
- Results accepted in any order; the scheduler does not reorder, since the address travels with the data.

Test Plan:
- Reset/idle: hold i_rst_n=0 with random inputs -> all outputs 0; release with no i_start -> o_busy stays 0 for 100 cycles.
- Single core, NUM_CORES=1, H_RES=4, V_RES=2, core ready every cycle, 3-cycle fixed latency -> addresses 0..7 offered in order, 8 writes with o_wr_addr 0..7, o_done once, 1 cycle after last write.
- Backpressure: all i_job_ready=0 for 10 cycles mid-frame -> o_job_valid=0, x/y/addr frozen; resume -> next address continues without gaps or duplicates.
- Fairness: all 4 cores hold i_res_valid=1 continuously -> grants cycle 0,1,2,3,0..., no core starved; exactly one o_wr_en per cycle.
- Simultaneous issue and grant in one cycle -> outstanding count unchanged; full 320x240 frame with random core latencies -> exactly 76800 writes covering each address once, then o_done.
- Mid-frame reset at pixel 1000, then i_start -> outputs cleared immediately; restart from addr 0; i_start pulsed during busy has no effect.

Source files
------------

// File: rtl/mandelbrot_frame_scheduler.sv
// mandelbrot_frame_scheduler
//
// Renders one Mandelbrot frame: walks every pixel (x, y) of an H_RES x V_RES
// frame in raster order, hands each pixel to one of NUM_CORES iteration cores,
// and funnels the returned colours onto the single frame-buffer write port.
//
// Handshake rule for both the job and the result channels: a transfer
// happens in the cycle where valid and ready are both high.  Valid never
// depends on a transfer completing later; the scheduler's job valid and
// result ready are combinational from the cores' ready/valid and the
// scheduler's registered state.
//
// Ports
//   clk, i_rst_n           clock, asynchronous active-low reset
//   i_start                1-cycle pulse, starts a frame (ignored while busy)
//   o_busy                 high from accepted start until done
//   o_done                 1-cycle pulse after the last pixel is written
//   o_job_valid/i_job_ready  one-hot job offer per core / core can accept
//   o_job_x/o_job_y/o_job_addr  pixel offered (shared by all cores)
//   i_res_valid/o_res_ready  result available per core / one-hot grant
//   i_res_addr/i_res_data  per-core result address and colour, core k at
//                          [k*W +: W]
//   o_wr_en/o_wr_addr/o_wr_data  frame-buffer write port
//   o_state                current FSM state (debug)

module mandelbrot_frame_scheduler #(
   parameter int NUM_CORES  = 4,
   parameter int H_RES      = 320,
   parameter int V_RES      = 240,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 12
) (
   input  logic                            clk,
   input  logic                            i_rst_n,
   input  logic                            i_start,
   output logic                            o_busy,
   output logic                            o_done,
   output logic [NUM_CORES-1:0]            o_job_valid,
   input  logic [NUM_CORES-1:0]            i_job_ready,
   output logic [9:0]                      o_job_x,
   output logic [8:0]                      o_job_y,
   output logic [ADDR_WIDTH-1:0]           o_job_addr,
   input  logic [NUM_CORES-1:0]            i_res_valid,
   output logic [NUM_CORES-1:0]            o_res_ready,
   input  logic [NUM_CORES*ADDR_WIDTH-1:0] i_res_addr,
   input  logic [NUM_CORES*DATA_WIDTH-1:0] i_res_data,
   output logic                            o_wr_en,
   output logic [ADDR_WIDTH-1:0]           o_wr_addr,
   output logic [DATA_WIDTH-1:0]           o_wr_data,
   output logic [1:0]                      o_state
);

   localparam int PIXELS = H_RES * V_RES;
   localparam int CNT_W  = $clog2(PIXELS) + 1;
   localparam int PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      DRAIN    = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t                state, state_next;
   logic [9:0]            x;
   logic [8:0]            y;
   logic [ADDR_WIDTH-1:0] addr;
   logic [CNT_W-1:0]      outstanding;
   logic [PTR_W-1:0]      rr_ptr;

   logic                  job_fire;
   logic                  last_pixel;
   logic [NUM_CORES-1:0]  job_valid;
   logic [NUM_CORES-1:0]  res_grant;
   logic                  grant_any;
   logic [PTR_W-1:0]      grant_idx;
   logic [PTR_W-1:0]      ptr_next;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;

   assign last_pixel = (x == 10'(H_RES - 1)) && (y == 9'(V_RES - 1));

   // Job offer: lowest-index ready core gets the current pixel.  The
   // descending scan leaves the lowest ready index as the final winner.
   always_comb begin
      job_valid = '0;
      if (state == DISPATCH) begin
         for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (i_job_ready[k]) begin
               job_valid    = '0;
               job_valid[k] = 1'b1;
            end
         end
      end
   end

   // job_valid is only ever set where the core is ready, so any set bit
   // is a completed handshake.
   assign job_fire = |job_valid;

   // Round-robin result arbiter.  First pass searches from the pointer to
   // the top; if nothing is found there, the second pass takes the lowest
   // valid core below the pointer, which is the wrap-around continuation.
   always_comb begin
      res_grant = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      sel_addr  = '0;
      sel_data  = '0;
      if (state != IDLE) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_any && (k >= int'(rr_ptr)) && i_res_valid[k]) begin
               grant_any    = 1'b1;
               grant_idx    = PTR_W'(k);
               res_grant[k] = 1'b1;
            end
         end
         for (int k = 0; k < NUM_CORES; k++) begin
            if (!grant_any && i_res_valid[k]) begin
               grant_any    = 1'b1;
               grant_idx    = PTR_W'(k);
               res_grant[k] = 1'b1;
            end
         end
         for (int k = 0; k < NUM_CORES; k++) begin
            if (res_grant[k]) begin
               sel_addr = i_res_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
               sel_data = i_res_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
         end
      end
   end

   assign ptr_next = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);

   // FSM state register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state and status outputs.  DRAIN exits once nothing is
   // outstanding: the last grant decremented the counter, and the cycle in
   // which the counter reads zero is the cycle its write is being driven,
   // so DONE lands exactly one cycle after the final write.
   always_comb begin
      state_next = state;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) state_next = DISPATCH;
         end
         DISPATCH: begin
            o_busy = 1'b1;
            if (job_fire && last_pixel) state_next = DRAIN;
         end
         DRAIN: begin
            o_busy = 1'b1;
            if (outstanding == '0) state_next = DONE;
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pixel walker, outstanding counter, arbiter pointer and write stage.
   // The address register steps by one alongside x/y, so it always equals
   // y*H_RES + x without a multiplier.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x           <= '0;
         y           <= '0;
         addr        <= '0;
         outstanding <= '0;
         rr_ptr      <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         if (state == IDLE && i_start) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
         end else if (job_fire) begin
            if (last_pixel) begin
               x    <= '0;
               y    <= '0;
               addr <= '0;
            end else if (x == 10'(H_RES - 1)) begin
               x    <= '0;
               y    <= y + 9'd1;
               addr <= addr + ADDR_WIDTH'(1);
            end else begin
               x    <= x + 10'd1;
               addr <= addr + ADDR_WIDTH'(1);
            end
         end

         if (job_fire && !grant_any) begin
            outstanding <= outstanding + CNT_W'(1);
         end else if (!job_fire && grant_any) begin
            outstanding <= outstanding - CNT_W'(1);
         end

         if (grant_any && !job_fire) begin
            assert (outstanding != '0);
         end

         if (grant_any) begin
            rr_ptr  <= ptr_next;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
         end
         wr_en <= grant_any;
      end
   end

   assign o_job_valid = job_valid;
   assign o_job_x     = x;
   assign o_job_y     = y;
   assign o_job_addr  = addr;
   assign o_res_ready = res_grant;
   assign o_wr_en     = wr_en;
   assign o_wr_addr   = wr_addr;
   assign o_wr_data   = wr_data;
   assign o_state     = state;

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// tb_mandelbrot_frame_scheduler
//
// Drives the scheduler with a small frame and four behavioural cores.  Each
// core keeps its accepted jobs in a shared job list with a due cycle; the
// reference model tracks the expected pixel sequence as a plain counter, the
// expected arbiter grant from the round-robin rule, and the write that must
// follow each grant one cycle later.

module tb_mandelbrot_frame_scheduler;

   localparam int NC   = 4;
   localparam int HR   = 20;
   localparam int VR   = 10;
   localparam int AW   = 17;
   localparam int DW   = 12;
   localparam int NPIX = HR * VR;

   typedef struct {
      int core;
      int addr;
      int due;
   } job_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             busy, done;
   logic [NC-1:0]    job_valid, job_ready, res_valid, res_ready;
   logic [9:0]       job_x;
   logic [8:0]       job_y;
   logic [AW-1:0]    job_addr, wr_addr;
   logic [NC*AW-1:0] res_addr;
   logic [NC*DW-1:0] res_data;
   logic             wr_en;
   logic [DW-1:0]    wr_data;
   logic [1:0]       dbg_state;

   mandelbrot_frame_scheduler #(
      .NUM_CORES (NC),
      .H_RES     (HR),
      .V_RES     (VR),
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW)
   ) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .o_busy     (busy),
      .o_done     (done),
      .o_job_valid(job_valid),
      .i_job_ready(job_ready),
      .o_job_x    (job_x),
      .o_job_y    (job_y),
      .o_job_addr (job_addr),
      .i_res_valid(res_valid),
      .o_res_ready(res_ready),
      .i_res_addr (res_addr),
      .i_res_data (res_data),
      .o_wr_en    (wr_en),
      .o_wr_addr  (wr_addr),
      .o_wr_data  (wr_data),
      .o_state    (dbg_state)
   );

   // scoreboard / model state
   int      checks = 0;
   int      failures = 0;
   int      cyc = 0;
   job_t    jobs[$];
   bit      m_busy = 1'b0;
   bit      m_done = 1'b0;
   int      disp = 0;
   int      nwr = 0;
   int      ptr = 0;
   bit      pend_v = 1'b0;
   int      pend_a = 0;
   logic [DW-1:0] pend_d = '0;
   bit      seen [NPIX];
   int      done_cnt = 0;
   bit      in_order = 1'b0;
   bit      start_req = 1'b0;

   // core behaviour knobs
   logic [NC-1:0] ready_mask = '1;
   int      ready_pct = 50;
   int      lat_min = 1;
   int      lat_max = 8;
   int      cap = 4;
   bit      stall = 1'b0;

   function automatic logic [DW-1:0] colour(input int a);
      return DW'(a * 37 + 5);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
         $error("check %s did not hold", tag);
      end
   endtask

   task automatic model_reset();
      jobs.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      disp   = 0;
      nwr    = 0;
      ptr    = 0;
      pend_v = 1'b0;
   endtask

   // driver: present core behaviour for the coming cycle
   task automatic drive_inputs();
      int cnt  [NC];
      int fidx [NC];
      for (int k = 0; k < NC; k++) begin
         cnt[k]  = 0;
         fidx[k] = -1;
      end
      for (int j = 0; j < jobs.size(); j++) begin
         cnt[jobs[j].core]++;
         if (fidx[jobs[j].core] < 0) fidx[jobs[j].core] = j;
      end
      job_ready = '0;
      res_valid = '0;
      res_addr  = '0;
      res_data  = '0;
      if (!rst_n) begin
         job_ready = NC'($urandom);
         res_valid = NC'($urandom);
         for (int k = 0; k < NC; k++) begin
            res_addr = res_addr | ((NC*AW)'(AW'($urandom)) << (k * AW));
            res_data = res_data | ((NC*DW)'(DW'($urandom)) << (k * DW));
         end
         start = 1'($urandom);
      end else begin
         for (int k = 0; k < NC; k++) begin
            logic [NC-1:0] m;
            m = ready_mask >> k;
            if (m[0] && !stall && cnt[k] < cap && int'($urandom_range(0, 99)) < ready_pct)
               job_ready = job_ready | (NC'(1) << k);
            if (fidx[k] >= 0 && jobs[fidx[k]].due <= cyc) begin
               res_valid = res_valid | (NC'(1) << k);
               res_addr  = res_addr | ((NC*AW)'(AW'(jobs[fidx[k]].addr)) << (k * AW));
               res_data  = res_data | ((NC*DW)'(colour(jobs[fidx[k]].addr)) << (k * DW));
            end
         end
         start     = start_req;
         start_req = 1'b0;
      end
   endtask

   // scoreboard: compare outputs with the model, then advance the model
   task automatic observe();
      logic [NC-1:0] exp_v, exp_g, tmp;
      int   gk, jk, idx;
      bit   next_done;
      job_t j;
      exp_v = '0;
      exp_g = '0;
      gk = -1;
      jk = -1;
      next_done = 1'b0;
      if (!rst_n) begin
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_job_valid", 32'(job_valid), 32'd0);
         chk("rst_res_ready", 32'(res_ready), 32'd0);
         chk("rst_wr_en", 32'(wr_en), 32'd0);
         chk("rst_wr_addr", 32'(wr_addr), 32'd0);
         chk("rst_wr_data", 32'(wr_data), 32'd0);
         chk("rst_job_addr", 32'(job_addr), 32'd0);
         chk("rst_job_xy", 32'({job_x, job_y}), 32'd0);
         chk("rst_state", 32'(dbg_state), 32'd0);
         model_reset();
      end else begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         if (done === 1'b1) done_cnt++;
         if (m_busy && disp < NPIX) begin
            chk("job_x", 32'(job_x), 32'(disp % HR));
            chk("job_y", 32'(job_y), 32'(disp / HR));
            chk("job_addr", 32'(job_addr), 32'(disp));
            for (int k = 0; k < NC; k++) begin
               tmp = job_ready >> k;
               if (tmp[0] && exp_v == '0) begin
                  exp_v = NC'(1) << k;
                  jk = k;
               end
            end
         end
         chk("job_valid", 32'(job_valid), 32'(exp_v));
         if (m_busy || m_done) begin
            for (int i = 0; i < NC; i++) begin
               tmp = res_valid >> ((ptr + i) % NC);
               if (gk < 0 && tmp[0]) gk = (ptr + i) % NC;
            end
         end
         if (gk >= 0) exp_g = NC'(1) << gk;
         chk("res_ready", 32'(res_ready), 32'(exp_g));
         chk("wr_en", 32'(wr_en), 32'(pend_v));
         if (pend_v) begin
            chk("wr_addr", 32'(wr_addr), 32'(pend_a));
            chk("wr_data", 32'(wr_data), 32'(pend_d));
            if (in_order) chk("wr_order", 32'(wr_addr), 32'(nwr));
            idx = int'(wr_addr);
            if (idx < NPIX) begin
               chk("wr_dup", 32'(seen[idx]), 32'd0);
               seen[idx] = 1'b1;
            end
            nwr++;
            if (nwr == NPIX) next_done = 1'b1;
         end
         if (jk >= 0) begin
            j.core = jk;
            j.addr = disp;
            j.due  = cyc + int'($urandom_range(lat_min, lat_max));
            jobs.push_back(j);
            disp++;
         end
         pend_v = 1'b0;
         if (gk >= 0) begin
            for (int i = jobs.size() - 1; i >= 0; i--)
               if (jobs[i].core == gk) idx = i;
            pend_v = 1'b1;
            pend_a = jobs[idx].addr;
            pend_d = colour(pend_a);
            jobs.delete(idx);
            ptr = (gk + 1) % NC;
         end
         if (m_done) begin
            m_busy = 1'b0;
         end else if (!m_busy && start) begin
            m_busy = 1'b1;
            disp   = 0;
            nwr    = 0;
            for (int i = 0; i < NPIX; i++) seen[i] = 1'b0;
         end
         if (next_done) m_busy = 1'b0;
         m_done = next_done;
      end
      cyc++;
   endtask

   task automatic cycle();
      drive_inputs();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input int budget, input int stall_at, input int bstart_at);
      int n, stall_n, cov;
      n = 0;
      stall_n = 0;
      done_cnt = 0;
      disp = 0;
      start_req = 1'b1;
      while (done_cnt == 0 && n < budget) begin
         stall = (stall_at >= 0 && disp >= stall_at && stall_n < 10);
         if (stall) stall_n++;
         if (n == bstart_at) start_req = 1'b1;
         cycle();
         n++;
      end
      stall = 1'b0;
      chk("frame_timeout", 32'(n < budget), 32'd1);
      repeat (3) cycle();
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("write_count", 32'(nwr), 32'(NPIX));
      cov = 0;
      for (int i = 0; i < NPIX; i++) cov += int'(seen[i]);
      chk("coverage", 32'(cov), 32'(NPIX));
   endtask

   initial begin
      int n;
      // reset with random inputs, then idle without start
      repeat (20) cycle();
      rst_n = 1'b1;
      repeat (100) cycle();

      // single core, always ready, fixed 3-cycle latency: in-order writes
      ready_mask = 4'b0001; ready_pct = 100; lat_min = 3; lat_max = 3; cap = 8;
      in_order = 1'b1;
      run_frame(3000, -1, -1);
      in_order = 1'b0;

      // all cores, random readiness/latency, a 10-cycle ready stall and a
      // start pulse while busy
      ready_mask = 4'b1111; ready_pct = 60; lat_min = 1; lat_max = 8; cap = 4;
      run_frame(5000, 50, 30);

      // long latency so several cores hold results at once
      ready_pct = 100; lat_min = 12; lat_max = 12; cap = 8;
      run_frame(5000, -1, -1);

      // mid-frame reset, then a clean restart from address 0
      ready_pct = 80; lat_min = 1; lat_max = 10; cap = 4;
      disp = 0;
      start_req = 1'b1;
      n = 0;
      while (disp < 100 && n < 2000) begin
         cycle();
         n++;
      end
      chk("reset_point", 32'(disp >= 100), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_job_valid", 32'(job_valid), 32'd0);
      chk("async_wr_en", 32'(wr_en), 32'd0);
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (5) cycle();
      run_frame(5000, -1, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
